// File: rtl/frame_checker.sv
// Ingress frame checker: validates preamble/header/payload framing of a 16-bit stream,
// sums payload bytes, and exposes the last good header, checksum and counters over Avalon-MM.
module frame_checker #(
  parameter int MAX_PAYLOAD = 1500,
  parameter int CNT_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic [15:0] ingress_port_tdata,
  input  logic        ingress_port_tlast,
  input  logic        ingress_port_tvalid,
  output logic        ingress_port_tready
);

  localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);
  localparam logic [15:0] PRE_WORD  = 16'hAAAA;
  localparam logic [15:0] SFD_WORD  = 16'hAAAB;
  localparam logic [7:0]  CTRL_ADDR = 8'd24;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_DROP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           pre_cnt_q, pre_cnt_d;
  logic [2:0]           hdr_idx_q, hdr_idx_d;
  logic [15:0]          words_left_q, words_left_d;
  logic [31:0]          csum_acc_q, csum_acc_d;
  logic [31:0]          csum_vis_q, csum_vis_d;
  logic [7:0]           stage_q [16];
  logic [7:0]           stage_d [16];
  logic [7:0]           vis_q [16];
  logic [7:0]           vis_d [16];
  logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 err_q, err_d;
  logic [2:0]           code_q, code_d;
  logic                 stall_q, stall_d;
  logic [31:0]          readdata_q, readdata_d;

  logic        beat;
  logic        ctrl_wr;
  logic        frame_good;
  logic        frame_err;
  logic [2:0]  err_code;
  logic [15:0] len_word;
  logic [15:0] len_staged;
  logic [15:0] good_cnt16;
  logic [7:0]  rd_byte;
  logic        unused_wdata;

  // Reset also forces tready low so the source cannot push words during reset.
  assign ingress_port_tready = !stall_q && !reset;
  assign beat         = ingress_port_tvalid && ingress_port_tready;
  assign ctrl_wr      = chipselect && write && (address == CTRL_ADDR);
  assign len_word     = {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
  assign len_staged   = {stage_q[13], stage_q[12]};
  assign good_cnt16   = 16'(good_cnt_q);
  assign readdata     = readdata_q;
  assign unused_wdata = ^writedata[31:2];

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    hdr_idx_d    = hdr_idx_q;
    words_left_d = words_left_q;
    csum_acc_d   = csum_acc_q;
    csum_vis_d   = csum_vis_q;
    stage_d      = stage_q;
    vis_d        = vis_q;
    good_cnt_d   = good_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_d        = err_q;
    code_d       = code_q;
    stall_d      = stall_q;
    frame_good   = 1'b0;
    frame_err    = 1'b0;
    err_code     = 3'd0;

    if (beat) begin
      unique case (state_q)
        S_IDLE: begin
          if (ingress_port_tdata == PRE_WORD && !ingress_port_tlast) begin
            pre_cnt_d = 2'd1;
            state_d   = S_PRE;
          end else if (ingress_port_tdata == PRE_WORD) begin
            frame_err = 1'b1;
            err_code  = 3'd3;
          end else begin
            frame_err = 1'b1;
            err_code  = 3'd1;
            state_d   = ingress_port_tlast ? S_IDLE : S_DROP;
          end
        end
        S_PRE: begin
          if ((ingress_port_tdata == PRE_WORD && pre_cnt_q < 2'd3) ||
              (ingress_port_tdata == SFD_WORD && pre_cnt_q == 2'd3)) begin
            if (ingress_port_tlast) begin
              frame_err = 1'b1;
              err_code  = 3'd3;
              state_d   = S_IDLE;
            end else if (ingress_port_tdata == PRE_WORD) begin
              pre_cnt_d = pre_cnt_q + 2'd1;
            end else begin
              csum_acc_d = 32'd0;
              hdr_idx_d  = 3'd0;
              state_d    = S_HDR;
            end
          end else begin
            frame_err = 1'b1;
            err_code  = 3'd1;
            state_d   = ingress_port_tlast ? S_IDLE : S_DROP;
          end
        end
        S_HDR: begin
          stage_d[{hdr_idx_q, 1'b0}] = ingress_port_tdata[15:8];
          stage_d[{hdr_idx_q, 1'b1}] = ingress_port_tdata[7:0];
          hdr_idx_d = hdr_idx_q + 3'd1;
          case (hdr_idx_q)
            3'd6: begin
              if (ingress_port_tlast) begin
                frame_err = 1'b1;
                err_code  = 3'd3;
                state_d   = S_IDLE;
              end else if (len_word > MAX_LEN) begin
                frame_err = 1'b1;
                err_code  = 3'd2;
                state_d   = S_DROP;
              end
            end
            3'd7: begin
              if (len_staged == 16'd0) begin
                if (ingress_port_tlast) begin
                  frame_good = 1'b1;
                  state_d    = S_IDLE;
                end else begin
                  frame_err = 1'b1;
                  err_code  = 3'd4;
                  state_d   = S_DROP;
                end
              end else if (ingress_port_tlast) begin
                frame_err = 1'b1;
                err_code  = 3'd3;
                state_d   = S_IDLE;
              end else begin
                // Odd lengths round up: the final word still carries two summed bytes.
                words_left_d = 16'((17'(len_staged) + 17'd1) >> 1);
                state_d      = S_PAY;
              end
            end
            default: begin
              if (ingress_port_tlast) begin
                frame_err = 1'b1;
                err_code  = 3'd3;
                state_d   = S_IDLE;
              end
            end
          endcase
        end
        S_PAY: begin
          csum_acc_d   = csum_acc_q + 32'(ingress_port_tdata[15:8]) + 32'(ingress_port_tdata[7:0]);
          words_left_d = words_left_q - 16'd1;
          if (ingress_port_tlast) begin
            frame_good = (words_left_q == 16'd1);
            frame_err  = (words_left_q != 16'd1);
            err_code   = 3'd3;
            state_d    = S_IDLE;
          end else if (words_left_q == 16'd1) begin
            frame_err = 1'b1;
            err_code  = 3'd4;
            state_d   = S_DROP;
          end
        end
        S_DROP: begin
          if (ingress_port_tlast) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (frame_good) begin
      vis_d      = stage_d;
      csum_vis_d = csum_acc_d;
      good_cnt_d = (&good_cnt_q) ? good_cnt_q : good_cnt_q + CNT_WIDTH'(1);
      err_d      = 1'b0;
    end
    if (frame_err) begin
      err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 8'd1;
      err_d     = 1'b1;
      code_d    = err_code;
    end
    // A clear landing with a completion overrides the counters but not the header copy.
    if (ctrl_wr) begin
      stall_d = writedata[1];
      if (writedata[0]) begin
        good_cnt_d = '0;
        err_cnt_d  = 8'd0;
        err_d      = 1'b0;
        code_d     = 3'd0;
      end
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    if (address < 8'd16) begin
      rd_byte = vis_q[address[3:0]];
    end else begin
      case (address)
        8'd16:   rd_byte = csum_vis_q[7:0];
        8'd17:   rd_byte = csum_vis_q[15:8];
        8'd18:   rd_byte = csum_vis_q[23:16];
        8'd19:   rd_byte = csum_vis_q[31:24];
        8'd20:   rd_byte = good_cnt16[7:0];
        8'd21:   rd_byte = good_cnt16[15:8];
        8'd22:   rd_byte = err_cnt_q;
        8'd23:   rd_byte = {3'b000, code_q, err_q, (state_q != S_IDLE)};
        8'd24:   rd_byte = {6'b000000, stall_q, 1'b0};
        default: rd_byte = 8'h00;
      endcase
    end
    readdata_d = (chipselect && read) ? {24'h000000, rd_byte} : 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= 2'd0;
      hdr_idx_q    <= 3'd0;
      words_left_q <= 16'd0;
      csum_acc_q   <= 32'd0;
      csum_vis_q   <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        stage_q[i] <= 8'h00;
        vis_q[i]   <= 8'h00;
      end
      good_cnt_q   <= '0;
      err_cnt_q    <= 8'd0;
      err_q        <= 1'b0;
      code_q       <= 3'd0;
      stall_q      <= 1'b0;
      readdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      hdr_idx_q    <= hdr_idx_d;
      words_left_q <= words_left_d;
      csum_acc_q   <= csum_acc_d;
      csum_vis_q   <= csum_vis_d;
      stage_q      <= stage_d;
      vis_q        <= vis_d;
      good_cnt_q   <= good_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_q        <= err_d;
      code_q       <= code_d;
      stall_q      <= stall_d;
      readdata_q   <= readdata_d;
    end
  end

endmodule

// File: tb/tb_frame_checker.sv
// Self-checking bench for frame_checker: directed framing cases plus randomized frames
// scored against a frame-level model of the expected register contents.
module tb_frame_checker;
  localparam int CW = 4;
  localparam int GOOD_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] writedata = '0;
  logic        write = 1'b0;
  logic        chipselect = 1'b0;
  logic [7:0]  address = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic [15:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;

  always #5 clk = ~clk;

  frame_checker #(.MAX_PAYLOAD(1500), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .read(read), .readdata(readdata),
    .ingress_port_tdata(tdata), .ingress_port_tlast(tlast),
    .ingress_port_tvalid(tvalid), .ingress_port_tready(tready)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: what the register file should show after each whole frame.
  logic [7:0]  exp_hdr [16];
  logic [31:0] exp_csum;
  int          exp_good, exp_err;
  logic        exp_eflag;
  logic [2:0]  exp_code;

  // Frame under construction and its intended header/checksum.
  logic [15:0] fw [$];
  logic [15:0] pay_q [$];
  logic [7:0]  f_hdr [16];
  logic [31:0] f_csum;

  bit mon_en = 0;
  int stall_cycles;
  always @(negedge clk) begin
    if (!mon_en) stall_cycles = 0;
    else if (tvalid && !tready) stall_cycles = stall_cycles + 1;
  end

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) exp_hdr[i] = 8'h00;
    exp_csum = 0; exp_good = 0; exp_err = 0; exp_eflag = 0; exp_code = 0;
  endfunction

  function automatic void model_frame(input bit good, input logic [2:0] code);
    if (good) begin
      for (int i = 0; i < 16; i++) exp_hdr[i] = f_hdr[i];
      exp_csum  = f_csum;
      exp_good  = (exp_good < GOOD_MAX) ? exp_good + 1 : GOOD_MAX;
      exp_eflag = 0;
    end else begin
      exp_err   = (exp_err < 255) ? exp_err + 1 : 255;
      exp_eflag = 1;
      exp_code  = code;
    end
  endfunction

  function automatic void model_clear();
    exp_good = 0; exp_err = 0; exp_eflag = 0; exp_code = 0;
  endfunction

  function automatic void fill_pay(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
  endfunction

  function automatic void build(input logic [47:0] dst, input logic [47:0] src,
                                input logic [15:0] len, input logic [15:0] typ);
    fw = {16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAB};
    for (int i = 0; i < 6; i++) begin
      f_hdr[i]     = dst[47-8*i -: 8];
      f_hdr[6 + i] = src[47-8*i -: 8];
    end
    f_hdr[12] = len[7:0];
    f_hdr[13] = len[15:8];
    f_hdr[14] = typ[15:8];
    f_hdr[15] = typ[7:0];
    for (int i = 0; i < 8; i++) fw.push_back({f_hdr[2*i], f_hdr[2*i+1]});
    f_csum = 0;
    foreach (pay_q[i]) begin
      fw.push_back(pay_q[i]);
      f_csum = f_csum + 32'(pay_q[i][15:8]) + 32'(pay_q[i][7:0]);
    end
  endfunction

  function automatic void build_rand(input int len);
    fill_pay((len + 1) / 2);
    build({$urandom, $urandom}, {$urandom, $urandom}, 16'(len), 16'($urandom));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat();
    int n;
    bit got;
    n = 0;
    do begin
      @(negedge clk); got = tready;
      @(posedge clk); #1;
      n++;
    end while (!got && n < 2000);
    if (!got) check_eq("beat_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic send_frame(input bit clr_last);
    bit last;
    $display("frame: %0d words, first 0x%04h, clear_on_last=%0d", fw.size(), fw[0], clr_last);
    for (int i = 0; i < fw.size(); i++) begin
      last = (i == fw.size() - 1);
      tvalid = 1'b1; tdata = fw[i]; tlast = last;
      if (clr_last && last) begin
        chipselect = 1'b1; write = 1'b1; address = 8'd24; writedata = 32'h1;
      end
      send_beat();
      if (clr_last && last) begin chipselect = 1'b0; write = 1'b0; end
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = 8'(a);
    tick();
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = 8'(a); writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    logic [15:0] g;
    g = 16'(exp_good);
    for (int a = 0; a < 16; a++) begin
      rd(a, d); check_eq($sformatf("%s hdr%0d", tag, a), d, {24'h0, exp_hdr[a]});
    end
    for (int a = 0; a < 4; a++) begin
      rd(16 + a, d); check_eq($sformatf("%s csum%0d", tag, a), d, {24'h0, exp_csum[8*a +: 8]});
    end
    rd(20, d); check_eq({tag, " good_lo"}, d, {24'h0, g[7:0]});
    rd(21, d); check_eq({tag, " good_hi"}, d, {24'h0, g[15:8]});
    rd(22, d); check_eq({tag, " err_cnt"}, d, 32'(exp_err));
    rd(23, d); check_eq({tag, " status"}, d, {27'h0, exp_code, exp_eflag, 1'b0});
    rd(24, d); check_eq({tag, " ctrl"}, d, 32'h0);
    rd(31, d); check_eq({tag, " unmapped"}, d, 32'h0);
    tick(); check_eq({tag, " rd_idle"}, readdata, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int kind, len, nw, p;
    logic [2:0] code;
    bit good;

    repeat (3) @(posedge clk);
    #1;
    check_eq("tready_in_reset", {31'b0, tready}, 32'd0);
    check_eq("readdata_in_reset", readdata, 32'h0);
    reset = 1'b0;
    tick();
    model_reset();
    check_regs("reset");

    // Reference good frame: checksum 1+2+3+4.
    pay_q = {16'h0102, 16'h0304};
    build(48'h010203040506, 48'h111213141516, 16'd4, 16'h0800);
    send_frame(0); model_frame(1, 0);
    rd(16, d); check_eq("basic csum0", d, 32'h0A);
    rd(12, d); check_eq("basic len0", d, 32'h04);
    rd(23, d); check_eq("basic status", d, 32'h00);
    rd(20, d); check_eq("basic good", d, 32'h01);
    check_regs("basic");

    // Zero length, good then missing tlast.
    pay_q.delete();
    build({$urandom, $urandom}, {$urandom, $urandom}, 16'd0, 16'h86DD);
    send_frame(0); model_frame(1, 0); check_regs("zlen_good");
    fw.push_back(16'h5555);
    send_frame(0); model_frame(0, 4); check_regs("zlen_notlast");

    // Backpressure: the stalled run must produce the same checksum as the clean run.
    wr(24, 32'h2);
    rd(24, d); check_eq("ctrl_stall_rd", d, 32'h2);
    check_eq("tready_stalled", {31'b0, tready}, 32'd0);
    wr(24, 32'h0);
    build_rand(40);
    send_frame(0); model_frame(1, 0); check_regs("bp_clean");
    mon_en = 1;
    fork
      send_frame(0);
      begin
        repeat (16) tick();
        wr(24, 32'h2);
        repeat (4) tick();
        wr(24, 32'h0);
      end
    join
    mon_en = 0;
    check_eq("bp_stall_cycles", 32'(stall_cycles), 32'd5);
    model_frame(1, 0); check_regs("bp_stalled");

    // Framing errors, each followed by a recovering good frame.
    fw = {16'hAAAA, 16'hAAAB, 16'h1234};
    send_frame(0); model_frame(0, 1); check_regs("short_pre");
    build_rand(7); send_frame(0); model_frame(1, 0); check_regs("recover1");
    fill_pay(750);
    build({$urandom, $urandom}, {$urandom, $urandom}, 16'd1500, 16'h0800);
    send_frame(0); model_frame(1, 0); check_regs("len1500");
    fill_pay(3);
    build({$urandom, $urandom}, {$urandom, $urandom}, 16'd1501, 16'h0800);
    send_frame(0); model_frame(0, 2); check_regs("len1501");
    build_rand(3); send_frame(0); model_frame(1, 0); check_regs("recover2");
    build_rand(8);
    fw = fw[0:13];
    send_frame(0); model_frame(0, 3); check_regs("early_tlast");
    build_rand(9); send_frame(0); model_frame(1, 0); check_regs("recover3");

    // Randomized frames with injected faults.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      good = 0; code = 0;
      case (kind)
        0: begin build_rand($urandom_range(0, 40)); good = 1; end
        1: begin
          build_rand($urandom_range(0, 20));
          p = $urandom_range(0, 3);
          fw[p] = fw[p] ^ 16'($urandom_range(1, 65535));
          code = 1;
        end
        2: begin
          fill_pay($urandom_range(0, 4));
          build({$urandom, $urandom}, {$urandom, $urandom},
                16'($urandom_range(1501, 1600)), 16'($urandom));
          code = 2;
        end
        3: begin
          if ($urandom_range(0, 1) == 0) begin
            build_rand($urandom_range(0, 20));
            p = $urandom_range(0, 6);
            fw = fw[0:4 + p];
          end else begin
            len = $urandom_range(4, 40);
            nw = (len + 1) / 2;
            build_rand(len);
            p = $urandom_range(0, nw - 2);
            fw = fw[0:12 + p];
          end
          code = 3;
        end
        default: begin
          build_rand($urandom_range(0, 40));
          fw.push_back(16'($urandom));
          code = 4;
        end
      endcase
      send_frame(0); model_frame(good, code);
      check_regs($sformatf("rand%0d_k%0d", f, kind));
    end

    // Clear landing on the completing beat.
    build_rand(6);
    send_frame(1); model_frame(1, 0); model_clear(); check_regs("clr_on_done");

    // Counter saturation.
    for (int i = 0; i < 260; i++) begin
      fw = {16'h1234};
      send_frame(0); model_frame(0, 1);
    end
    check_regs("err_sat");
    wr(24, 32'h1); model_clear(); check_regs("after_clear");
    for (int i = 0; i < GOOD_MAX + 2; i++) begin
      build_rand($urandom_range(0, 4)); send_frame(0); model_frame(1, 0);
    end
    check_regs("good_sat");

    // Asynchronous reset in the middle of a payload.
    pay_q.delete();
    for (int i = 0; i < 10; i++) pay_q.push_back(16'h1111);
    build({$urandom, $urandom}, {$urandom, $urandom}, 16'd20, 16'h0800);
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1; tdata = fw[i]; tlast = 1'b0;
      send_beat();
    end
    tvalid = 1'b0;
    chipselect = 1'b1; read = 1'b1; address = 8'd23;
    tick();
    check_eq("busy_mid_frame", readdata, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst readdata", readdata, 32'h0);
    check_eq("async_rst tready", {31'b0, tready}, 32'd0);
    chipselect = 1'b0; read = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    fw = fw[16:$];
    send_frame(0); model_frame(0, 1); check_regs("post_reset_tail");
    build_rand(11); send_frame(0); model_frame(1, 0); check_regs("post_reset_good");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
